// File: rtl/ram_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_scan_ctrl_pkg
// Shared geometry of the 32x4 RAM and the controller state encoding.
//   ADDR_W, DATA_W, DEPTH : RAM shape
//   LAST_ADDR             : final address of a fill or scan pass
//   state_t               : controller states
// ---------------------------------------------------------------------------
package ram_scan_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 32;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    HOLD = 3'd4,
    FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/ram_scan_ctrl_dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Loadable down-counter with a terminal-count strobe. Generic enough to serve
// as a hex display rate divider (reload on tc_o).
//   clk, rst_n  : clock, asynchronous active-low reset (count clears to 0)
//   load_i      : load load_val_i (wins over en_i)
//   en_i        : count down; the count saturates at zero
//   load_val_i  : value loaded; tc_o fires load_val_i+1 enabled cycles later
//   tc_o        : high while enabled and the count is zero
// ---------------------------------------------------------------------------
module dwell_counter #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ram_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ram_scan_ctrl
// Controller for a 32x4 synchronous RAM: either fills every location with one
// value (one write per cycle) or scans every location, holding each captured
// word on the display outputs for DWELL cycles.
//   CLOCK_50, resetn      : clock, asynchronous active-low reset
//   start, stop, mode     : launch (sampled in IDLE), abort, 0=scan / 1=fill
//   fill_data             : fill value, sampled with start
//   ram_addr/wren/wdata   : RAM request port
//   ram_rdata             : RAM read data, valid one cycle after ram_addr
//   disp_addr/data/valid  : last captured location for the hex display
//   busy, done            : not IDLE; one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module ram_scan_ctrl
  import ram_scan_ctrl_pkg::*;
#(
  parameter int DWELL = 50000000,
  parameter int CNT_W = 26
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [DATA_W-1:0] fill_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  // HOLD lasts load value + 1 cycles, so load DWELL-1 for DWELL cycles.
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic              cnt_load, cnt_en, cnt_tc;

  dwell_counter #(
    .W(CNT_W)
  ) u_dwell (
    .clk       (CLOCK_50),
    .rst_n     (resetn),
    .load_i    (cnt_load),
    .en_i      (cnt_en),
    .load_val_i(DWELL_LOAD),
    .tc_o      (cnt_tc)
  );

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    fill_d       = fill_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          fill_d  = fill_data;
          addr_d  = '0;
          state_d = mode ? FILL : RD;
        end
      end
      FILL: begin
        if (addr_q == LAST_ADDR) begin
          state_d = FIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        // ram_rdata now reflects the address presented during RD.
        disp_addr_d  = addr_q;
        disp_data_d  = ram_rdata;
        disp_valid_d = 1'b1;
        cnt_load     = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          if (addr_q == LAST_ADDR) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = RD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort from any busy state; freeze the address so nothing advances.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      addr_d  = addr_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      fill_q       <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      fill_q       <= fill_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // Write strobe is decoded straight from the state register, so an
  // asynchronous reset drops it in the same instant.
  assign ram_addr   = addr_q;
  assign ram_wren   = (state_q == FILL);
  assign ram_wdata  = (state_q == FILL) ? fill_q : '0;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_scan_ctrl
// Bench for ram_scan_ctrl with DWELL=3 and a behavioural 32x4 synchronous RAM.
// Stimulus pushes the expected writes, display captures and done pulses
// (with the cycle each must appear in) into a queue; a monitor sampling on
// the falling edge pops and compares every event the DUT produces.
// ---------------------------------------------------------------------------
module tb_ram_scan_ctrl;

  localparam int DWELL     = 3;
  localparam int CNT_W     = 4;
  localparam int SCAN_PER  = DWELL + 2;
  localparam int SCAN_DONE = 32 * SCAN_PER;
  localparam int FILL_DONE = 32;

  typedef enum logic [1:0] {EV_WR = 2'd0, EV_DISP = 2'd1, EV_DONE = 2'd2} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    logic [4:0] addr;
    logic [3:0] data;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] fill_data;
  logic [4:0] ram_addr;
  logic       ram_wren;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic [4:0] disp_addr;
  logic [3:0] disp_data;
  logic       disp_valid;
  logic       busy;
  logic       done;

  logic [3:0] mem     [32];
  logic [3:0] exp_mem [32];
  ev_t        exp_q   [$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] disp_prev = '0;

  ram_scan_ctrl #(
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .fill_data (fill_data),
    .ram_addr  (ram_addr),
    .ram_wren  (ram_wren),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM: registered read, old data on collision.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pack_ev(input ev_kind_t k, input logic [4:0] a,
                                          input logic [3:0] d, input int c);
    return {1'b0, k, a, d, c[19:0]};
  endfunction

  task automatic push_ev(input ev_kind_t k, input int a, input logic [3:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.addr = a[4:0];
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [4:0] a, input logic [3:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: actual addr=%0d data=%h at cycle %0d, required no event",
               k.name(), a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_%s", e.kind.name()), pack_ev(k, a, d, cyc),
            pack_ev(e.kind, e.addr, e.data, e.cyc));
    end
  endtask

  // Monitor: report overdue expectations, then match what the DUT shows now.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_%s: actual none by cycle %0d, required addr=%0d data=%h at cycle %0d",
               exp_q[0].kind.name(), cyc, exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (ram_wren) observe(EV_WR, ram_addr, ram_wdata);
    if (disp_valid && ({disp_addr, disp_data, 1'b1} != disp_prev))
      observe(EV_DISP, disp_addr, disp_data);
    disp_prev = {disp_addr, disp_data, disp_valid};
    if (done) observe(EV_DONE, 5'd0, 4'd0);
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Launch an operation from a falling edge; e is the edge that samples start.
  task automatic start_op(input logic m, input logic [3:0] d, input int n_wr,
                          input int n_disp, input bit with_done, output int e);
    e = cyc + 1;
    if (m) begin
      for (int k = 0; k < n_wr; k++) begin
        push_ev(EV_WR, k, d, e + k);
        exp_mem[k] = d;
      end
      if (with_done) push_ev(EV_DONE, 0, 4'd0, e + FILL_DONE);
    end else begin
      for (int k = 0; k < n_disp; k++) push_ev(EV_DISP, k, exp_mem[k], e + 2 + SCAN_PER * k);
      if (with_done) push_ev(EV_DONE, 0, 4'd0, e + SCAN_DONE);
    end
    mode      = m;
    fill_data = d;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    mode      = 1'b0;
    fill_data = 4'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_wren"},   ram_wren,   0);
    check({tag, "_ram_addr"},   ram_addr,   0);
    check({tag, "_ram_wdata"},  ram_wdata,  0);
    check({tag, "_disp_addr"},  disp_addr,  0);
    check({tag, "_disp_data"},  disp_data,  0);
    check({tag, "_disp_valid"}, disp_valid, 0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_done"},       done,       0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 4'(i);
      exp_mem[i] = 4'(i);
    end
    resetn    = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    mode      = 1'b0;
    fill_data = 4'd0;
    #2;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_after_reset_busy", busy, 0);

    // Fill with A: 32 writes, done one cycle later, then idle.
    start_op(1'b1, 4'hA, 32, 0, 1'b1, e);
    wait_cyc(e + FILL_DONE);
    check("fill_busy_in_fin", busy, 1);
    wait_cyc(e + FILL_DONE + 1);
    check("fill_busy_after_done", busy, 0);

    // Scan: every location shows A; a start pulse mid-scan must be ignored.
    start_op(1'b0, 4'h0, 0, 32, 1'b1, e);
    wait_cyc(e + 50);
    start     = 1'b1;
    mode      = 1'b1;
    fill_data = 4'hF;
    @(negedge clk);
    start     = 1'b0;
    mode      = 1'b0;
    fill_data = 4'h0;
    check("scan_busy_after_ignored_start", busy, 1);
    wait_cyc(e + SCAN_DONE + 1);
    check("scan_busy_after_done", busy, 0);
    check("scan_last_disp_addr", disp_addr, 31);

    // Abort during HOLD of address 7.
    start_op(1'b0, 4'h0, 0, 8, 1'b0, e);
    wait_cyc(e + 2 + SCAN_PER * 7 + 1);
    check("abort_disp_addr_in_hold", disp_addr, 7);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_disp_addr_kept", disp_addr, 7);
    check("abort_disp_valid_kept", disp_valid, 1);
    repeat (6) @(negedge clk);
    check("abort_still_idle", busy, 0);

    // stop has priority over start in IDLE.
    start     = 1'b1;
    stop      = 1'b1;
    mode      = 1'b1;
    fill_data = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("prio_stop_over_start_busy", busy, 0);
    end
    start     = 1'b0;
    stop      = 1'b0;
    mode      = 1'b0;
    fill_data = 4'h0;
    @(negedge clk);

    // Reset mid-fill: prefill with 5, then refill with A and reset at address 12.
    start_op(1'b1, 4'h5, 32, 0, 1'b1, e);
    wait_cyc(e + FILL_DONE + 1);
    check("prefill_busy_after_done", busy, 0);
    start_op(1'b1, 4'hA, 12, 0, 1'b0, e);
    wait_cyc(e + 11);
    @(posedge clk);
    #2;
    check("pre_reset_addr12_wren", ram_wren, 1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_fill_reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("after_reset_release_busy", busy, 0);

    // Readback scan: 0..11 hold A, 12..31 still hold 5.
    start_op(1'b0, 4'h0, 0, 32, 1'b1, e);
    wait_cyc(e + SCAN_DONE + 4);
    check("readback_disp_data_last", disp_data, 4'h5);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
